// File: rtl/nn_pkg.sv
// nn_pkg: shared float32 constants, argmax FSM state type and IEEE-754 field helpers.
package nn_pkg;
   localparam int FLOAT_W = 32;
   localparam logic [7:0] EXP_MAX = 8'hFF;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;
   function automatic logic [7:0] f32_exp(input logic [FLOAT_W-1:0] x);
      return x[30:23];
   endfunction
   function automatic logic [22:0] f32_man(input logic [FLOAT_W-1:0] x);
      return x[22:0];
   endfunction
   function automatic logic [30:0] f32_mag(input logic [FLOAT_W-1:0] x);
      return x[30:0];
   endfunction
   function automatic logic f32_is_nan(input logic [FLOAT_W-1:0] x);
      return f32_exp(x) == EXP_MAX && f32_man(x) != '0;
   endfunction
endpackage

// File: rtl/float32_gt.sv
// float32_gt: combinational float32 "a > b" treating -0 and +0 as equal.
// ARGMAX_NAN_CHECK_EN adds a_nan/b_nan flags.
module float32_gt
   import nn_pkg::*;
(
   input logic [FLOAT_W-1:0] a,
   input logic [FLOAT_W-1:0] b,
   output logic gt
`ifdef ARGMAX_NAN_CHECK_EN
   , output logic a_nan
   , output logic b_nan
`endif
);
   logic [30:0] am, bm;
   assign am = f32_mag(a);
   assign bm = f32_mag(b);
   assign gt = (am == '0 && bm == '0) ? 1'b0 :
               (a[31] != b[31]) ? !a[31] :
               a[31] ? am < bm : am > bm;
`ifdef ARGMAX_NAN_CHECK_EN
   assign a_nan = f32_is_nan(a);
   assign b_nan = f32_is_nan(b);
`endif
endmodule

// File: rtl/nn_argmax_seq.sv
// nn_argmax_seq: snapshots a float32 vector on done_in rising edge and scans one element per clock for the argmax.
// ARGMAX_NAN_CHECK_EN makes NaNs ineligible and adds the nan_seen output.
module nn_argmax_seq
   import nn_pkg::*;
#(
   parameter int SIZE = 10,
   localparam int IDX_W = SIZE > 1 ? $clog2(SIZE) : 1
) (
   input logic clk,
   input logic rst,
   input logic [FLOAT_W*SIZE-1:0] data,
   input logic done_in,
   output logic [IDX_W-1:0] class_idx,
   output logic [FLOAT_W-1:0] max_value,
   output logic valid,
   output logic busy
`ifdef ARGMAX_NAN_CHECK_EN
   , output logic nan_seen
`endif
);
   argmax_state_t state;
   logic done_q, trig, gt, take, last;
   logic [FLOAT_W*SIZE-1:0] snap;
   logic [FLOAT_W-1:0] best, cand, nb;
   logic [IDX_W-1:0] best_idx, i, nb_idx;
   assign trig = done_in && !done_q;
   assign cand = snap[FLOAT_W*i +: FLOAT_W];
   assign last = i == IDX_W'(SIZE - 1);
`ifdef ARGMAX_NAN_CHECK_EN
   logic cand_nan, best_nan, nan_acc;
   float32_gt u_gt (.a(cand), .b(best), .gt(gt), .a_nan(cand_nan), .b_nan(best_nan));
   // A NaN best means no real element has been seen yet, so any real candidate seeds it.
   assign take = !cand_nan && (best_nan || gt);
`else
   float32_gt u_gt (.a(cand), .b(best), .gt(gt));
   assign take = gt;
`endif
   assign nb = take ? cand : best;
   assign nb_idx = take ? i : best_idx;
   assign valid = state == DONE;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done_q <= 1'b0;
         class_idx <= '0;
         max_value <= '0;
`ifdef ARGMAX_NAN_CHECK_EN
         nan_seen <= 1'b0;
`endif
      end else begin
         done_q <= done_in;
         if (state == IDLE && trig) begin
            snap <= data;
            best <= data[FLOAT_W-1:0];
            best_idx <= '0;
            i <= IDX_W'(1);
            state <= SIZE == 1 ? DONE : SCAN;
`ifdef ARGMAX_NAN_CHECK_EN
            nan_acc <= f32_is_nan(data[FLOAT_W-1:0]);
`endif
            if (SIZE == 1) begin
               class_idx <= '0;
               max_value <= data[FLOAT_W-1:0];
`ifdef ARGMAX_NAN_CHECK_EN
               nan_seen <= f32_is_nan(data[FLOAT_W-1:0]);
`endif
            end
         end else if (state == SCAN) begin
            best <= nb;
            best_idx <= nb_idx;
            i <= i + 1'b1;
`ifdef ARGMAX_NAN_CHECK_EN
            nan_acc <= nan_acc | cand_nan;
`endif
            // Results land on the same edge as the final compare so they are current while valid is high.
            if (last) begin
               state <= DONE;
               class_idx <= nb_idx;
               max_value <= nb;
`ifdef ARGMAX_NAN_CHECK_EN
               nan_seen <= nan_acc | cand_nan;
`endif
            end
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_nn_argmax_seq.sv
// tb_nn_argmax_seq: directed and randomized argmax scans checked against an order-key reference model.
module tb_nn_argmax_seq;
   localparam int SIZE = 10;
   localparam int IDX_W = 4;
   logic clk = 1'b0;
   logic rst, done_in, valid, busy;
   logic [32*SIZE-1:0] data;
   logic [IDX_W-1:0] class_idx;
   logic [31:0] max_value;
`ifdef ARGMAX_NAN_CHECK_EN
   logic nan_seen;
`endif
   int total = 0;
   int passed = 0;
   always #5 clk = ~clk;

   nn_argmax_seq #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst), .data(data), .done_in(done_in),
      .class_idx(class_idx), .max_value(max_value), .valid(valid), .busy(busy)
`ifdef ARGMAX_NAN_CHECK_EN
      , .nan_seen(nan_seen)
`endif
   );

   function automatic logic is_nan(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 0;
   endfunction

   // Maps a float to an unsigned key whose integer order is the float order (signed zeros merged).
   function automatic logic [31:0] order_key(input logic [31:0] x);
      logic [31:0] y;
      y = (x == 32'h80000000) ? 32'h0 : x;
      return y[31] ? ~y : (y | 32'h80000000);
   endfunction

   function automatic int ref_idx(input logic [31:0] v[SIZE]);
      int b;
      b = -1;
      for (int j = 0; j < SIZE; j++) begin
`ifdef ARGMAX_NAN_CHECK_EN
         if (is_nan(v[j])) continue;
`endif
         if (b < 0 || order_key(v[j]) > order_key(v[b])) b = j;
      end
      return b < 0 ? 0 : b;
   endfunction

   function automatic logic any_nan(input logic [31:0] v[SIZE]);
      logic r;
      r = 1'b0;
      for (int j = 0; j < SIZE; j++) r |= is_nan(v[j]);
      return r;
   endfunction

   task automatic load(input logic [31:0] v[SIZE]);
      for (int j = 0; j < SIZE; j++) data[32*j +: 32] = v[j];
   endtask

   task automatic fill(output logic [31:0] v[SIZE], input logic [31:0] x);
      for (int j = 0; j < SIZE; j++) v[j] = x;
   endtask

   // Raises done_in and returns edges from trigger to first valid (-1 on timeout) and busy just after the trigger.
   task automatic run_scan(output int lat, output logic b0);
      done_in = 1'b1;
      lat = -1;
      b0 = 1'b0;
      for (int k = 0; k < SIZE + 8; k++) begin
         @(posedge clk); #1;
         if (k == 0) b0 = busy;
         if (valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic idle_edge();
      done_in = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      done_in = 1'b0;
      data = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (class_idx !== 4'd0) $display("FAIL reset_idx got %0d want 0", class_idx); else passed++;
      total++; if (max_value !== 32'h0) $display("FAIL reset_val got %h want 0", max_value); else passed++;
      total++; if ({valid, busy} !== 2'b00) $display("FAIL reset_vb got %b want 00", {valid, busy}); else passed++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [31:0] v[SIZE];
      logic [31:0] neg[SIZE] = '{32'hC0A00000, 32'hC0900000, 32'hC0800000, 32'hC0600000, 32'hC0400000,
                                 32'hC0200000, 32'hC0000000, 32'hBFC00000, 32'hBF800000, 32'hBF000000};
      int exp_idx[4] = '{7, 2, 9, 0};
      logic [31:0] exp_val[4] = '{32'h40400000, 32'h40000000, 32'hBF000000, 32'h00000000};
      int lat;
      logic b0;
      for (int c = 0; c < 4; c++) begin
         fill(v, 32'h3F800000);
         if (c == 0) v[7] = 32'h40400000;
         if (c == 1) begin v[2] = 32'h40000000; v[5] = 32'h40000000; end
         if (c == 2) v = neg;
         if (c == 3) begin fill(v, 32'hBF800000); v[0] = 32'h0; v[4] = 32'h80000000; end
         load(v);
         run_scan(lat, b0);
         total++; if (lat != SIZE - 1) $display("FAIL dir%0d_latency got %0d want %0d", c, lat, SIZE - 1); else passed++;
         total++; if (b0 !== 1'b1) $display("FAIL dir%0d_busy got %b want 1", c, b0); else passed++;
         total++; if (class_idx !== IDX_W'(exp_idx[c])) $display("FAIL dir%0d_idx got %0d want %0d", c, class_idx, exp_idx[c]); else passed++;
         total++; if (max_value !== exp_val[c]) $display("FAIL dir%0d_val got %h want %h", c, max_value, exp_val[c]); else passed++;
         @(posedge clk); #1;
         total++; if ({valid, busy} !== 2'b00) $display("FAIL dir%0d_after got %b want 00", c, {valid, busy}); else passed++;
         idle_edge();
      end
   endtask

   task automatic test_random();
      logic [31:0] v[SIZE];
      logic [31:0] pal[6] = '{32'h3F800000, 32'hBF800000, 32'h0, 32'h80000000, 32'h40000000, 32'hC0000000};
      int lat, e;
      logic b0;
      for (int t = 0; t < 25; t++) begin
         for (int j = 0; j < SIZE; j++) begin
            case ($urandom_range(0, 3))
               0: v[j] = $urandom;
               1: v[j] = pal[$urandom_range(0, 5)];
               2: v[j] = {1'b0, 8'd127 + 8'($urandom_range(0, 3)), 23'($urandom_range(0, 7))};
               default: v[j] = (j == 0) ? 32'h3F800000 : v[$urandom_range(0, j - 1)];
            endcase
         end
         load(v);
         e = ref_idx(v);
         run_scan(lat, b0);
         total++; if (lat != SIZE - 1) $display("FAIL rnd%0d_latency got %0d want %0d", t, lat, SIZE - 1); else passed++;
         total++; if (class_idx !== IDX_W'(e)) $display("FAIL rnd%0d_idx got %0d want %0d", t, class_idx, e); else passed++;
         total++; if (max_value !== v[e]) $display("FAIL rnd%0d_val got %h want %h", t, max_value, v[e]); else passed++;
`ifdef ARGMAX_NAN_CHECK_EN
         total++; if (nan_seen !== any_nan(v)) $display("FAIL rnd%0d_nan got %b want %b", t, nan_seen, any_nan(v)); else passed++;
`endif
         @(posedge clk); #1;
         idle_edge();
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] v[SIZE];
      int lat;
      logic b0;
      logic seen;
      fill(v, 32'h3F800000);
      v[6] = 32'h40A00000;
      load(v);
      done_in = 1'b1;
      seen = 1'b0;
      repeat (4) begin @(posedge clk); #1; seen |= valid; end
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; seen |= valid | busy; end
      total++; if (seen !== 1'b0) $display("FAIL abort_no_valid got %b want 0", seen); else passed++;
      rst = 1'b0;
      run_scan(lat, b0);
      total++; if (lat != SIZE - 1) $display("FAIL abort_restart_latency got %0d want %0d", lat, SIZE - 1); else passed++;
      total++; if (class_idx !== 4'd6) $display("FAIL abort_restart_idx got %0d want 6", class_idx); else passed++;
      @(posedge clk); #1;
      idle_edge();
   endtask

   task automatic test_snapshot();
      logic [31:0] a[SIZE], b[SIZE];
      int nvalid, first_idx;
      logic [31:0] first_val;
      logic busy_after, grab;
      fill(a, 32'h3F800000);
      a[2] = 32'h40400000;
      fill(b, 32'h3F800000);
      b[8] = 32'h41000000;
      load(a);
      done_in = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      load(b);
      done_in = 1'b0;
      @(posedge clk); #1;
      done_in = 1'b1;
      nvalid = 0; first_idx = -1; first_val = '0; busy_after = 1'b1; grab = 1'b0;
      for (int k = 0; k < 2 * SIZE; k++) begin
         @(posedge clk); #1;
         if (grab) begin busy_after = busy; grab = 1'b0; end
         if (valid) begin
            if (nvalid == 0) begin first_idx = int'(class_idx); first_val = max_value; grab = 1'b1; end
            nvalid++;
         end
      end
      total++; if (nvalid != 1) $display("FAIL snap_valid_count got %0d want 1", nvalid); else passed++;
      total++; if (first_idx != 2) $display("FAIL snap_idx got %0d want 2", first_idx); else passed++;
      total++; if (first_val !== 32'h40400000) $display("FAIL snap_val got %h want 40400000", first_val); else passed++;
      total++; if (busy_after !== 1'b0) $display("FAIL snap_busy_after got %b want 0", busy_after); else passed++;
      idle_edge();
   endtask

`ifdef ARGMAX_NAN_CHECK_EN
   task automatic test_nan();
      logic [31:0] v[SIZE];
      int lat;
      logic b0;
      fill(v, 32'h3F800000);
      v[0] = 32'h7FC00000;
      v[3] = 32'h40800000;
      load(v);
      run_scan(lat, b0);
      total++; if (class_idx !== 4'd3) $display("FAIL nan_idx got %0d want 3", class_idx); else passed++;
      total++; if (nan_seen !== 1'b1) $display("FAIL nan_seen got %b want 1", nan_seen); else passed++;
      @(posedge clk); #1;
      idle_edge();
      fill(v, 32'h7FC00001);
      v[0] = 32'hFF800123;
      load(v);
      run_scan(lat, b0);
      total++; if (class_idx !== 4'd0) $display("FAIL allnan_idx got %0d want 0", class_idx); else passed++;
      total++; if (max_value !== 32'hFF800123) $display("FAIL allnan_val got %h want ff800123", max_value); else passed++;
      total++; if (nan_seen !== 1'b1) $display("FAIL allnan_seen got %b want 1", nan_seen); else passed++;
      @(posedge clk); #1;
      idle_edge();
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_reset_abort();
      test_snapshot();
`ifdef ARGMAX_NAN_CHECK_EN
      test_nan();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
